piece_spawner: RTL and testbench
================================

PIECE_SPAWNER -- requirements
Module: piece_spawner

Interface
REQ-001 The interface SHALL have one clock and a synchronous, active-high reset, as listed in REQ-002 and REQ-003.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 rand_piece  input  3  free-running piece code from the generator, sampled each cycle, values 0..6.
REQ-005 spawn_req  input  1  game controller requests the next piece; one-cycle pulse.
REQ-006 rotate_cw / rotate_ccw  input  1 each  rotate the active piece one step.
REQ-007 cur_piece  output  3  active piece code: 0=I, 1=O, 2=T, 3=S, 4=Z, 5=J, 6=L.
REQ-008 next_piece  output  3  preview piece code.
REQ-009 rotation  output  2  active rotation: 0=spawn, then clockwise 1, 2, 3.
REQ-010 shape  output  16  4x4 occupancy mask of cur_piece at the current rotation; row-major, bit 15 = row 0 col 0.
REQ-011 valid  output  1  high while a piece is active.
REQ-012 spawn_ack  output  1  one-cycle pulse in the cycle a new cur_piece becomes visible.

Function
REQ-013 The FSM SHALL have three states:
- S_INIT: fill the preview.
- S_LOAD: promote the preview and refill it.
- S_ACTIVE: a piece is in play.
REQ-014 In S_INIT, an accepted candidate (REQ-020) SHALL load next_piece and transition to S_LOAD.
REQ-015 In S_LOAD, an accepted candidate SHALL do the following on the same edge, then transition to S_ACTIVE:
- cur_piece <= next_piece
- next_piece <= candidate
- rotation <= 0
- valid <= 1
- spawn_ack pulses high for one cycle.
REQ-016 In S_ACTIVE:
- spawn_req SHALL transition to S_LOAD, with valid low during S_LOAD.
- spawn_req in S_INIT or S_LOAD SHALL be ignored, not queued.
REQ-017 Rotation, S_ACTIVE only:
- rotate_cw: rotation+1 mod 4.
- rotate_ccw: rotation-1 mod 4.
- Both high at once: no change.
- Rotation in other states: ignored.
- spawn_req in the same cycle takes priority and the rotate is dropped.
REQ-018 shape SHALL be combinational from the cur_piece and rotation registers, and 16'h0000 while valid=0.
- O SHALL give 16'h0660 at all four rotations.
REQ-019 An out-of-range candidate (7) SHALL be treated as 0.
REQ-020 Without bag mode, every candidate is accepted.
- Reset deassertion to valid=1 SHALL be exactly 2 cycles.
- spawn_req to spawn_ack SHALL be exactly 1 cycle.

Reset
REQ-021 The rst SHALL force the following on the next edge, overriding any in-progress load or rotate:
- state = S_INIT
- cur_piece = 0, next_piece = 0, rotation = 0
- valid = 0, spawn_ack = 0, shape = 0
- bag bits cleared.

Configuration
REQ-022 Macro PIECE_7BAG_EN SHALL control bag mode.
- Defined: a 7-bit bag register SHALL be kept, and a candidate SHALL be accepted only if its bag bit is clear.
- On rejection, the FSM SHALL hold its state and retry with the next cycle's rand_piece.
- On acceptance, the candidate's bag bit SHALL be set.
- If setting that bit makes all 7 set, the bag SHALL be cleared on the same edge.
- Each accept latency SHALL be at most 7 cycles, given a cycling generator.
- Undefined: no bag register; behaviour per REQ-020.

Structure
REQ-023 Package piece_pkg SHALL hold the following:
- the piece-code enum
- the FSM state enum
- the 16-bit shape table indexed [piece][rotation]
- NUM_PIECES = 7.
REQ-024 Shape lookup SHALL be a sub-module piece_shape_rom: inputs piece and rotation, output shape; purely combinational.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, rand_piece = 2 then 0: valid=1 at cycle 2; cur_piece=2, next_piece=0, rotation=0, shape=16'h4E00; spawn_ack pulses once.
- cur=I (0), four rotate_cw pulses: rotation 1, 2, 3, 0; shape returns to 16'h0F00.
- spawn_req and rotate_cw in the same cycle: rotate dropped; the next cycle shows the new cur = old next and rotation = 0.
- rotate_cw and rotate_ccw together: rotation unchanged. Then a second spawn_req while in S_LOAD: no extra spawn_ack.
- rst asserted while in S_LOAD: all outputs 0, valid=0; restart follows REQ-020 timing.
- PIECE_7BAG_EN defined, 14 spawns with a cycling rand_piece:
  - each group of 7 accepted codes is a permutation of 0..6;
  - an already-used code is stalled;
  - the bag clears after the 7th accept.

Source files
------------

// File: rtl/piece_pkg.sv
// piece_pkg: shared types and constants for the piece spawner.
//   Piece codes, FSM states, the per-piece/per-rotation 4x4 occupancy table,
//   and a helper that folds the out-of-range generator code onto piece I.
package piece_pkg;

  localparam int NUM_PIECES = 7;

  typedef enum logic [2:0] {
    P_I = 3'd0,
    P_O = 3'd1,
    P_T = 3'd2,
    P_S = 3'd3,
    P_Z = 3'd4,
    P_J = 3'd5,
    P_L = 3'd6
  } piece_e;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,   // fill the preview slot
    S_LOAD   = 2'd1,   // promote preview to active, refill preview
    S_ACTIVE = 2'd2    // a piece is in play
  } state_e;

  // 4x4 masks, row-major, bit 15 = row 0 col 0.
  // I uses the full 4x4 box, O never moves, the rest rotate in the
  // top-left 3x3 box (standard rotation-system layout).
  localparam logic [15:0] SHAPE_TABLE [NUM_PIECES][4] = '{
    '{16'h0F00, 16'h2222, 16'h00F0, 16'h4444},   // I
    '{16'h0660, 16'h0660, 16'h0660, 16'h0660},   // O
    '{16'h4E00, 16'h4640, 16'h0E40, 16'h4C40},   // T
    '{16'h6C00, 16'h4620, 16'h06C0, 16'h8C40},   // S
    '{16'hC600, 16'h2640, 16'h0C60, 16'h4C80},   // Z
    '{16'h8E00, 16'h6440, 16'h0E20, 16'h44C0},   // J
    '{16'h2E00, 16'h4460, 16'h0E80, 16'hC440}    // L
  };

  // The generator can emit 7; that code is treated as piece I.
  function automatic logic [2:0] sanitize_piece(input logic [2:0] code);
    logic [2:0] res;
    if (code == 3'd7) begin
      res = P_I;
    end else begin
      res = code;
    end
    return res;
  endfunction

endpackage

// File: rtl/piece_shape_rom.sv
// piece_shape_rom: combinational shape lookup.
//   Ports: piece (3b code), rotation (2b) -> shape (16b 4x4 mask).
//   An illegal piece code returns an empty mask.
module piece_shape_rom
  import piece_pkg::*;
(
  input  logic [2:0]  piece,
  input  logic [1:0]  rotation,
  output logic [15:0] shape
);

  always_comb begin
    shape = 16'h0000;
    if (piece != 3'd7) begin
      shape = SHAPE_TABLE[piece][rotation];
    end
  end

endmodule

// File: rtl/piece_spawner.sv
// piece_spawner: active/preview piece sequencer with rotation tracking.
//   Ports: clk, rst (sync, active-high); rand_piece, spawn_req, rotate_cw,
//   rotate_ccw in; cur_piece, next_piece, rotation, shape, valid, spawn_ack out.
//   Optional bag mode via macro PIECE_7BAG_EN: each group of 7 accepted
//   pieces is a permutation of all seven codes; repeats stall the load.
module piece_spawner
  import piece_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rand_piece,
  input  logic        spawn_req,
  input  logic        rotate_cw,
  input  logic        rotate_ccw,
  output logic [2:0]  cur_piece,
  output logic [2:0]  next_piece,
  output logic [1:0]  rotation,
  output logic [15:0] shape,
  output logic        valid,
  output logic        spawn_ack
);

  state_e      state;
  state_e      state_nxt;

  logic [2:0]  cand;
  logic        accept;

  // Decodes from the output process.
  logic        load_preview;
  logic        promote;
  logic        rot_en;
  logic [1:0]  rot_nxt;

  logic [15:0] rom_shape;

  assign cand = sanitize_piece(rand_piece);

`ifdef PIECE_7BAG_EN
  // One bit per piece already dealt in the current bag.
  logic [6:0] bag;
  logic [6:0] bag_set;
  logic       take;

  assign accept  = ~bag[cand];
  assign bag_set = bag | (7'b000_0001 << cand);
  assign take    = load_preview;

  always_ff @(posedge clk) begin
    if (rst) begin
      bag <= 7'b000_0000;
    end else if (take) begin
      // Dealing the last unused piece empties the bag on the same edge.
      bag <= (&bag_set) ? 7'b000_0000 : bag_set;
    end
  end
`else
  assign accept = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: begin
        if (accept) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (spawn_req) begin
          state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output decodes
  // ---------------------------------------------------------------------
  always_comb begin
    load_preview = 1'b0;
    promote      = 1'b0;
    rot_en       = 1'b0;
    rot_nxt      = rotation;
    case (state)
      S_INIT: begin
        load_preview = accept;
      end
      S_LOAD: begin
        load_preview = accept;
        promote      = accept;
      end
      S_ACTIVE: begin
        // A spawn request wins over rotation; opposing rotations cancel.
        if (!spawn_req && (rotate_cw ^ rotate_ccw)) begin
          rot_en  = 1'b1;
          rot_nxt = rotate_cw ? (rotation + 2'd1) : (rotation - 2'd1);
        end
      end
      default: begin
        load_preview = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Piece / rotation datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_piece  <= 3'd0;
      next_piece <= 3'd0;
      rotation   <= 2'd0;
      valid      <= 1'b0;
      spawn_ack  <= 1'b0;
    end else begin
      spawn_ack <= promote;
      if (load_preview) begin
        next_piece <= cand;
      end
      if (promote) begin
        cur_piece <= next_piece;
        rotation  <= 2'd0;
        valid     <= 1'b1;
      end else if ((state == S_ACTIVE) && spawn_req) begin
        valid <= 1'b0;
      end
      if (rot_en) begin
        rotation <= rot_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shape: straight from the registers, blanked while no piece is active.
  // ---------------------------------------------------------------------
  piece_shape_rom u_rom (
    .piece    (cur_piece),
    .rotation (rotation),
    .shape    (rom_shape)
  );

  assign shape = valid ? rom_shape : 16'h0000;

endmodule

// File: tb/tb_piece_spawner.sv
// tb_piece_spawner: directed and randomized bench for piece_spawner.
//   A behavioural model (fill countdown, used-code list, geometric rotation
//   of spawn masks) is compared against the DUT every cycle after reset.
module tb_piece_spawner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rand_piece = 3'd0;
  logic        spawn_req = 1'b0;
  logic        rotate_cw = 1'b0;
  logic        rotate_ccw = 1'b0;
  logic [2:0]  cur_piece;
  logic [2:0]  next_piece;
  logic [1:0]  rotation;
  logic [15:0] shape;
  logic        valid;
  logic        spawn_ack;

  always #5 clk = ~clk;

  piece_spawner dut (
    .clk        (clk),
    .rst        (rst),
    .rand_piece (rand_piece),
    .spawn_req  (spawn_req),
    .rotate_cw  (rotate_cw),
    .rotate_ccw (rotate_ccw),
    .cur_piece  (cur_piece),
    .next_piece (next_piece),
    .rotation   (rotation),
    .shape      (shape),
    .valid      (valid),
    .spawn_ack  (spawn_ack)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  localparam logic [15:0] SPAWN_MASK [7] = '{
    16'h0F00, 16'h0660, 16'h4E00, 16'h6C00, 16'hC600, 16'h8E00, 16'h2E00
  };

  logic [2:0] m_cur, m_next;
  logic [1:0] m_rot;
  logic       m_valid, m_ack;
  int         m_need;      // accepted candidates still needed before play
  int         used[$];     // codes dealt from the current bag
  bit         model_on = 1'b0;

  // Rotate a mask clockwise inside the top-left n x n box.
  function automatic logic [15:0] rot_once(input logic [15:0] m, input int n);
    logic [15:0] o;
    int src, dst;
    o = 16'h0000;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        src = 15 - (4 * r + c);
        dst = 15 - (4 * c + (n - 1 - r));
        if (m[src]) o[dst] = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic logic [15:0] expected_shape(input logic [2:0] p, input logic [1:0] r);
    logic [15:0] m;
    int n;
    m = SPAWN_MASK[p];
    if (p == 3'd1) return m;
    n = (p == 3'd0) ? 4 : 3;
    for (int k = 0; k < int'(r); k++) m = rot_once(m, n);
    return m;
  endfunction

  task automatic model_edge();
    logic [2:0] c;
    bit acc;
    m_ack = 1'b0;
    if (rst) begin
      m_cur = 3'd0; m_next = 3'd0; m_rot = 2'd0; m_valid = 1'b0;
      m_need = 2;
      used.delete();
    end else if (m_need > 0) begin
      c = (rand_piece == 3'd7) ? 3'd0 : rand_piece;
      acc = 1'b1;
`ifdef PIECE_7BAG_EN
      foreach (used[i]) if (used[i] == int'(c)) acc = 1'b0;
      if (acc) begin
        used.push_back(int'(c));
        if (used.size() == 7) used.delete();
      end
`endif
      if (acc) begin
        if (m_need == 2) begin
          m_next = c;
          m_need = 1;
        end else begin
          m_cur = m_next; m_next = c; m_rot = 2'd0;
          m_valid = 1'b1; m_ack = 1'b1; m_need = 0;
        end
      end
    end else if (spawn_req) begin
      m_valid = 1'b0;
      m_need = 1;
    end else if (rotate_cw != rotate_ccw) begin
      m_rot = 2'((int'(m_rot) + (rotate_cw ? 1 : 3)) % 4);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [15:0] es;
    if (model_on) begin
      es = m_valid ? expected_shape(m_cur, m_rot) : 16'h0000;
      vectors++;
      if ({cur_piece, next_piece, rotation, valid, spawn_ack, shape} !==
          {m_cur, m_next, m_rot, m_valid, m_ack, es}) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t: dut cur=%0d next=%0d rot=%0d valid=%0b ack=%0b shape=%h / model cur=%0d next=%0d rot=%0d valid=%0b ack=%0b shape=%h",
                 $time, cur_piece, next_piece, rotation, valid, spawn_ack, shape,
                 m_cur, m_next, m_rot, m_valid, m_ack, es);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [2:0] rp, input logic sr,
                       input logic cw, input logic ccw);
    rst = r; rand_piece = rp; spawn_req = sr; rotate_cw = cw; rotate_ccw = ccw;
    @(posedge clk);
    model_edge();
    model_on = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_valid", 16'(valid), 16'd0);
    chk("reset_shape", shape, 16'h0000);
    chk("reset_cur", 16'(cur_piece), 16'd0);

`ifndef PIECE_7BAG_EN
    // Reset release: preview fills, then first piece is live on cycle 2.
    cycle(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("init_valid", 16'(valid), 16'd0);
    chk("init_next", 16'(next_piece), 16'd2);
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("first_valid", 16'(valid), 16'd1);
    chk("first_cur", 16'(cur_piece), 16'd2);
    chk("first_next", 16'(next_piece), 16'd0);
    chk("first_rot", 16'(rotation), 16'd0);
    chk("first_shape", shape, 16'h4E00);
    chk("first_ack", 16'(spawn_ack), 16'd1);
    cycle(1'b0, 3'd5, 1'b0, 1'b0, 1'b0);
    chk("first_ack_drop", 16'(spawn_ack), 16'd0);

    // Bring I into play, rotate it a full turn.
    cycle(1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    chk("load_valid_low", 16'(valid), 16'd0);
    chk("load_shape_zero", shape, 16'h0000);
    cycle(1'b0, 3'd5, 1'b0, 1'b0, 1'b0);
    chk("i_cur", 16'(cur_piece), 16'd0);
    chk("i_shape", shape, 16'h0F00);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 3'(k), 1'b0, 1'b1, 1'b0);
      chk("i_rot_cw", 16'(rotation), 16'((k + 1) % 4));
      if (k == 0) chk("i_shape_r1", shape, 16'h2222);
    end
    chk("i_shape_full_turn", shape, 16'h0F00);

    // Spawn and rotate together: rotate is dropped.
    cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    chk("spawn_rot_dropped", 16'(rotation), 16'd1);
    cycle(1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    chk("spawn_cur_old_next", 16'(cur_piece), 16'd5);
    chk("spawn_next", 16'(next_piece), 16'd1);
    chk("spawn_rot_zero", 16'(rotation), 16'd0);
    chk("spawn_shape_j", shape, 16'h8E00);

    // Opposing rotations cancel.
    cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    chk("both_rot_hold", 16'(rotation), 16'd1);

    // spawn_req during the load cycle is not queued.
    cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    chk("o_ack", 16'(spawn_ack), 16'd1);
    chk("o_shape", shape, 16'h0660);
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("no_extra_ack", 16'(spawn_ack), 16'd0);
    chk("no_extra_valid", 16'(valid), 16'd1);

    // Out-of-range candidate becomes I.
    cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("code7_as_i", 16'(next_piece), 16'd0);

    // Reset in the middle of a load, then restart timing.
    cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    chk("rst_load_bus", {cur_piece, next_piece, rotation, valid, spawn_ack, 5'd0}, 16'h0000);
    chk("rst_load_shape", shape, 16'h0000);
    cycle(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    chk("restart_c1_valid", 16'(valid), 16'd0);
    cycle(1'b0, 3'd6, 1'b0, 1'b0, 1'b0);
    chk("restart_c2_valid", 16'(valid), 16'd1);
    chk("restart_cur", 16'(cur_piece), 16'd3);
    chk("restart_next", 16'(next_piece), 16'd6);
`else
    begin
      int acks = 0;
      int stalls = 0;
      logic [6:0] seen [2];
      logic prev_valid;
      seen[0] = 7'd0; seen[1] = 7'd0;
      prev_valid = 1'b0;
      for (int g = 0; g < 400 && acks < 14; g++) begin
        cycle(1'b0, 3'(g % 7), valid, 1'b0, 1'b0);
        if (spawn_ack) begin
          seen[acks / 7][cur_piece] = 1'b1;
          acks++;
        end
        if (acks > 0 && !valid && !prev_valid) stalls++;
        prev_valid = valid;
      end
      chk("bag_spawn_count", 16'(acks), 16'd14);
      chk("bag_perm_first", 16'(seen[0]), 16'h007F);
      chk("bag_perm_second", 16'(seen[1]), 16'h007F);
      chk("bag_stall_seen", 16'(stalls > 0), 16'd1);
    end
`endif

    // Randomized traffic under the per-cycle model compare.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) == 0,
            3'($urandom_range(0, 7)),
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
